id_ex_register: RTL and testbench
=================================

# id_ex_register

ID/EX pipeline register for the five-stage MIPS core, with integrated load-use hazard detection. It captures decoded control, operand data and register addresses from ID at each clock and presents them to EX. Its registered RS/RT/RD addresses and control bits feed the EX-stage forwarding logic and ALU muxes. When a load in EX feeds the instruction in ID, it raises `stall_o` and inserts exactly one bubble, so MEM→EX forwarding can resolve the dependency on the next cycle.

## Interface
Parameters:
- `DATA_W`, 32, operand/immediate width
- `CNT_W`, 16, stall-counter width

Ports:
- `clk_i` input 1: clock, rising edge
- `rst_i` input 1: reset, asynchronous, active-low
- `flush_i` input 1: branch/jump flush; loads a bubble
- `RegWrite_i`, `MemtoReg_i`, `MemRead_i`, `MemWrite_i`, `ALUSrc_i`, `RegDst_i` input 1 each: ID control bits
- `ALUOp_i` input 2: ID ALU op class
- `RSdata_i`, `RTdata_i`, `imm_i` input DATA_W: register-file read data, sign-extended immediate
- `RSaddr_i`, `RTaddr_i`, `RDaddr_i` input 5: register fields of the instruction in ID
- `RegWrite_o`, `MemtoReg_o`, `MemRead_o`, `MemWrite_o`, `ALUSrc_o`, `RegDst_o` output 1 each: registered control
- `ALUOp_o` output 2: registered ALU op class
- `RSdata_o`, `RTdata_o`, `imm_o` output DATA_W: registered data
- `RSaddr_o`, `RTaddr_o`, `RDaddr_o` output 5: registered addresses, to forwarding logic
- `valid_o` output 1: EX holds a real instruction (0 = bubble)
- `stall_o` output 1: combinational; holds PC and IF/ID this cycle
- `stall_cnt_o` output CNT_W: saturating count of load-use bubbles inserted

## Operation
- Hazard detect (combinational): `stall_o = MemRead_o & valid_o & (RTaddr_o != 0) & ((RTaddr_o == RSaddr_i) | (RTaddr_o == RTaddr_i))`.
- Register update on each rising edge, in priority order:
  - Reset (async, `rst_i`=0): all registered outputs 0, `valid_o`=0, `stall_cnt_o`=0.
  - `flush_i`=1: load a bubble.
  - `stall_o`=1: load a bubble; increment `stall_cnt_o`.
  - Otherwise: capture every `*_i` into the matching `*_o`; `valid_o`=1.
- Bubble definition: all control bits 0, `ALUOp_o`=0, all three addresses 0, data/immediate 0, `valid_o`=0. Zeroed addresses guarantee the bubble never matches in forwarding.
- `stall_cnt_o` saturates at all-ones; no wrap.
- `flush_i` and `stall_o` in the same cycle: one bubble is loaded; the counter does not increment (the flush wins).
- No self-sustaining stall: after a bubble `MemRead_o`=0, so `stall_o` drops the next cycle. Every load-use stall is exactly one cycle.
- `rst_i` asserted mid-stall: outputs clear immediately (asynchronous), so `stall_o` falls combinationally. When reset releases, the next edge loads normally.
- Upstream contract: while `stall_o`=1, PC and IF/ID hold, so the same ID inputs reappear next cycle.

## Timing
- Latency: one cycle, ID inputs → `*_o`.
- `stall_o` has zero latency from `RSaddr_i`/`RTaddr_i` and from the registered outputs; it is valid before the edge it governs.
- Load-use sequence:
  - Edge N: the lw enters EX.
  - Cycle N: `stall_o`=1.
  - Edge N+1: bubble loaded.
  - Cycle N+1: `stall_o`=0.
  - Edge N+2: the dependent instruction enters EX; the lw is in WB→forwarded.

## Test plan
- Reset: drive all inputs nonzero, `rst_i`=0 with no clock edge → all outputs 0 and `stall_o`=0 immediately; release reset and clock once → outputs equal inputs, `valid_o`=1.
- Load-use on RS: load `MemRead_i`=1, `RTaddr_i`=8; next cycle `RSaddr_i`=8 → `stall_o`=1. Following edge: `valid_o`=0, `RegWrite_o`=0, `RSaddr_o`=0, `stall_cnt_o`=1. Next cycle `stall_o`=0; the next edge captures the dependent instruction with `RSaddr_o`=8.
- No false stall: the load writes $0 (`RTaddr`=0) and the next instruction reads $0 → `stall_o`=0, no bubble. The load writes $9 and the next reads $10/$11 → `stall_o`=0.
- Flush vs stall collision: stall condition true and `flush_i`=1 on the same edge → bubble loaded, `stall_cnt_o` unchanged.
- Counter saturation: `CNT_W`=4, force 17 load-use stalls → `stall_cnt_o`=15 and holds.
- Async reset mid-stall: `stall_o`=1, assert `rst_i` between edges → `stall_o` and all outputs go to 0 without a clock edge.

Source files
------------

// File: rtl/id_ex_register_if.sv
// ---------------------------------------------------------------------------
// id_ex_register_if
//
// Bundle of every signal between the ID stage and the ID/EX pipeline
// register, plus the registered outputs that go to EX and to the hazard
// and forwarding logic.
//
//   master : the ID/EX consumer side (drives *_i, observes *_o)
//   slave  : the ID/EX register itself (samples *_i, drives *_o)
//
// Signals:
//   flush_i                      branch/jump flush, loads a bubble
//   RegWrite_i .. RegDst_i       ID control bits
//   ALUOp_i                      ID ALU op class
//   RSdata_i, RTdata_i, imm_i    operand data and sign-extended immediate
//   RSaddr_i, RTaddr_i, RDaddr_i register fields of the instruction in ID
//   *_o                          registered copies presented to EX
//   valid_o                      EX holds a real instruction (0 = bubble)
//   stall_o                      load-use stall, holds PC and IF/ID
//   stall_cnt_o                  saturating count of load-use bubbles
// ---------------------------------------------------------------------------
interface id_ex_register_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              flush_i;

    logic              RegWrite_i;
    logic              MemtoReg_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic              ALUSrc_i;
    logic              RegDst_i;
    logic [1:0]        ALUOp_i;
    logic [DATA_W-1:0] RSdata_i;
    logic [DATA_W-1:0] RTdata_i;
    logic [DATA_W-1:0] imm_i;
    logic [4:0]        RSaddr_i;
    logic [4:0]        RTaddr_i;
    logic [4:0]        RDaddr_i;

    logic              RegWrite_o;
    logic              MemtoReg_o;
    logic              MemRead_o;
    logic              MemWrite_o;
    logic              ALUSrc_o;
    logic              RegDst_o;
    logic [1:0]        ALUOp_o;
    logic [DATA_W-1:0] RSdata_o;
    logic [DATA_W-1:0] RTdata_o;
    logic [DATA_W-1:0] imm_o;
    logic [4:0]        RSaddr_o;
    logic [4:0]        RTaddr_o;
    logic [4:0]        RDaddr_o;
    logic              valid_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output flush_i,
        output RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i,
        output ALUOp_i, RSdata_i, RTdata_i, imm_i, RSaddr_i, RTaddr_i, RDaddr_i,
        input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o,
        input  ALUOp_o, RSdata_o, RTdata_o, imm_o, RSaddr_o, RTaddr_o, RDaddr_o,
        input  valid_o, stall_o, stall_cnt_o
    );

    modport slave (
        input  flush_i,
        input  RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i,
        input  ALUOp_i, RSdata_i, RTdata_i, imm_i, RSaddr_i, RTaddr_i, RDaddr_i,
        output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o,
        output ALUOp_o, RSdata_o, RTdata_o, imm_o, RSaddr_o, RTaddr_o, RDaddr_o,
        output valid_o, stall_o, stall_cnt_o
    );
endinterface

// File: rtl/id_ex_register.sv
// ---------------------------------------------------------------------------
// id_ex_register
//
// ID/EX pipeline register of the five-stage MIPS core with load-use hazard
// detection. Each rising edge it captures the decoded instruction from ID
// and presents it to EX. When the load now sitting in EX writes a register
// that the instruction in ID reads, stall_o is raised for one cycle and a
// single bubble is inserted so MEM->EX forwarding can resolve the operand.
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active low
//   bus    : id_ex_register_if.slave, ID inputs and registered EX outputs
//
// Parameters:
//   DATA_W : operand/immediate width (must match the interface)
//   CNT_W  : stall counter width (must match the interface)
// ---------------------------------------------------------------------------
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    id_ex_register_if.slave      bus
);

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src;
        logic              reg_dst;
        logic [1:0]        alu_op;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs_addr;
        logic [4:0]        rt_addr;
        logic [4:0]        rd_addr;
        logic              valid;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_t           stage_q;
    stage_t           capture;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             stall;

    always_comb begin
        capture            = '0;
        capture.reg_write  = bus.RegWrite_i;
        capture.mem_to_reg = bus.MemtoReg_i;
        capture.mem_read   = bus.MemRead_i;
        capture.mem_write  = bus.MemWrite_i;
        capture.alu_src    = bus.ALUSrc_i;
        capture.reg_dst    = bus.RegDst_i;
        capture.alu_op     = bus.ALUOp_i;
        capture.rs_data    = bus.RSdata_i;
        capture.rt_data    = bus.RTdata_i;
        capture.imm        = bus.imm_i;
        capture.rs_addr    = bus.RSaddr_i;
        capture.rt_addr    = bus.RTaddr_i;
        capture.rd_addr    = bus.RDaddr_i;
        capture.valid      = 1'b1;
    end

    // A load into $0 never creates a dependency, and a bubble (valid=0,
    // mem_read=0) can never stall, so every stall lasts exactly one cycle.
    always_comb begin
        stall = stage_q.mem_read & stage_q.valid & (stage_q.rt_addr != 5'd0) &
                ((stage_q.rt_addr == bus.RSaddr_i) | (stage_q.rt_addr == bus.RTaddr_i));
    end

    // A bubble is the all-zero stage: zeroed addresses keep it from ever
    // matching in the forwarding unit. Flush outranks stall and does not
    // count as a load-use bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stage_q     <= '0;
            stall_cnt_q <= '0;
        end else if (bus.flush_i) begin
            stage_q <= '0;
        end else if (stall) begin
            stage_q <= '0;
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end else begin
            stage_q <= capture;
        end
    end

    assign bus.RegWrite_o  = stage_q.reg_write;
    assign bus.MemtoReg_o  = stage_q.mem_to_reg;
    assign bus.MemRead_o   = stage_q.mem_read;
    assign bus.MemWrite_o  = stage_q.mem_write;
    assign bus.ALUSrc_o    = stage_q.alu_src;
    assign bus.RegDst_o    = stage_q.reg_dst;
    assign bus.ALUOp_o     = stage_q.alu_op;
    assign bus.RSdata_o    = stage_q.rs_data;
    assign bus.RTdata_o    = stage_q.rt_data;
    assign bus.imm_o       = stage_q.imm;
    assign bus.RSaddr_o    = stage_q.rs_addr;
    assign bus.RTaddr_o    = stage_q.rt_addr;
    assign bus.RDaddr_o    = stage_q.rd_addr;
    assign bus.valid_o     = stage_q.valid;
    assign bus.stall_o     = stall;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// ---------------------------------------------------------------------------
// tb_id_ex_register
//
// Directed, table-driven bench for id_ex_register (CNT_W=4 so counter
// saturation is reachable). Each vector gives the ID inputs, the expected
// stall_o before the edge, and whether the edge must capture the inputs or
// load a bubble, plus the expected stall count afterwards.
// ---------------------------------------------------------------------------
module tb_id_ex_register;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef struct {
        logic        flush;
        logic [5:0]  ctrl;      // {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst}
        logic [1:0]  aluop;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic        exp_stall;
        logic        exp_valid;
        logic [3:0]  exp_cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    id_ex_register_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    id_ex_register #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic flush, logic [5:0] ctrl, logic [1:0] aluop,
                                logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [31:0] rs_data, logic [31:0] rt_data, logic [31:0] imm,
                                logic exp_stall, logic exp_valid, logic [3:0] exp_cnt);
        vec_t v;
        v.flush = flush; v.ctrl = ctrl; v.aluop = aluop;
        v.rs = rs; v.rt = rt; v.rd = rd;
        v.rs_data = rs_data; v.rt_data = rt_data; v.imm = imm;
        v.exp_stall = exp_stall; v.exp_valid = exp_valid; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    function automatic logic [118:0] exp_bundle(vec_t v);
        if (!v.exp_valid) return '0;
        return {v.ctrl, v.aluop, v.rs_data, v.rt_data, v.imm, v.rs, v.rt, v.rd};
    endfunction

    function automatic logic [118:0] act_bundle();
        return {bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o, bus.MemWrite_o,
                bus.ALUSrc_o, bus.RegDst_o, bus.ALUOp_o, bus.RSdata_o, bus.RTdata_o,
                bus.imm_o, bus.RSaddr_o, bus.RTaddr_o, bus.RDaddr_o};
    endfunction

    task automatic applyStimulus(vec_t v);
        bus.flush_i    = v.flush;
        bus.RegWrite_i = v.ctrl[5];
        bus.MemtoReg_i = v.ctrl[4];
        bus.MemRead_i  = v.ctrl[3];
        bus.MemWrite_i = v.ctrl[2];
        bus.ALUSrc_i   = v.ctrl[1];
        bus.RegDst_i   = v.ctrl[0];
        bus.ALUOp_i    = v.aluop;
        bus.RSaddr_i   = v.rs;
        bus.RTaddr_i   = v.rt;
        bus.RDaddr_i   = v.rd;
        bus.RSdata_i   = v.rs_data;
        bus.RTdata_i   = v.rt_data;
        bus.imm_i      = v.imm;
    endtask

    task automatic checkOutput(string name, logic [127:0] actual, logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic runVector(string tag, vec_t v);
        applyStimulus(v);
        #1;
        checkOutput({tag, "_stall"}, {127'd0, bus.stall_o}, {127'd0, v.exp_stall});
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid"}, {127'd0, bus.valid_o}, {127'd0, v.exp_valid});
        checkOutput({tag, "_cnt"}, {124'd0, bus.stall_cnt_o}, {124'd0, v.exp_cnt});
        checkOutput({tag, "_bundle"}, {9'd0, act_bundle()}, {9'd0, exp_bundle(v)});
    endtask

    localparam logic [5:0] C_LW  = 6'b111010;
    localparam logic [5:0] C_ALU = 6'b100001;
    localparam logic [5:0] C_SW  = 6'b000110;

    vec_t vecs[14];
    vec_t rst_vec;
    vec_t lw_vec;
    vec_t use_vec;
    logic [3:0] exp_cnt;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //               flush ctrl   op  rs  rt  rd  rs_data       rt_data       imm           stl vld cnt
        vecs[0]  = mk(0, C_LW,  2'd0, 4,  8,  0,  32'h0000_1000, 32'h0000_0000, 32'h0000_0010, 0, 1, 0);
        vecs[1]  = mk(0, C_ALU, 2'd2, 8,  5,  6,  32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1, 0, 1);
        vecs[2]  = mk(0, C_ALU, 2'd2, 8,  5,  6,  32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 0, 1, 1);
        vecs[3]  = mk(0, C_LW,  2'd0, 4,  0,  0,  32'h0000_2000, 32'h0000_0000, 32'h0000_0004, 0, 1, 1);
        vecs[4]  = mk(0, C_ALU, 2'd2, 0,  0,  7,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 1, 1);
        vecs[5]  = mk(0, C_LW,  2'd0, 3,  9,  0,  32'h0000_3000, 32'h0000_0000, 32'hFFFF_FFFC, 0, 1, 1);
        vecs[6]  = mk(0, C_ALU, 2'd2, 10, 11, 12, 32'hAAAA_0000, 32'h0000_BBBB, 32'h0000_0000, 0, 1, 1);
        vecs[7]  = mk(0, C_LW,  2'd0, 2,  12, 0,  32'h0000_4000, 32'h0000_0000, 32'h0000_0008, 0, 1, 1);
        vecs[8]  = mk(1, C_ALU, 2'd2, 1,  12, 13, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1, 0, 1);
        vecs[9]  = mk(0, C_ALU, 2'd2, 1,  12, 13, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 0, 1, 1);
        vecs[10] = mk(1, C_ALU, 2'd1, 14, 15, 16, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0001, 0, 0, 1);
        vecs[11] = mk(0, C_LW,  2'd0, 1,  5,  0,  32'h0000_5000, 32'h0000_0000, 32'h0000_0020, 0, 1, 1);
        vecs[12] = mk(0, C_SW,  2'd0, 2,  5,  0,  32'h0000_6000, 32'h5555_5555, 32'h0000_0030, 1, 0, 2);
        vecs[13] = mk(0, C_SW,  2'd0, 2,  5,  0,  32'h0000_6000, 32'h5555_5555, 32'h0000_0030, 0, 1, 2);

        // Reset with every input nonzero: outputs must be zero with no edge.
        rst_n   = 1'b0;
        rst_vec = mk(0, 6'b111111, 2'd3, 1, 2, 3, 32'hFFFF_0001, 32'hFFFF_0002, 32'hFFFF_0003, 0, 1, 0);
        applyStimulus(rst_vec);
        #2;
        checkOutput("reset_valid", {127'd0, bus.valid_o}, 128'd0);
        checkOutput("reset_stall", {127'd0, bus.stall_o}, 128'd0);
        checkOutput("reset_cnt", {124'd0, bus.stall_cnt_o}, 128'd0);
        checkOutput("reset_bundle", {9'd0, act_bundle()}, 128'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_valid", {127'd0, bus.valid_o}, 128'd1);
        checkOutput("release_bundle", {9'd0, act_bundle()}, {9'd0, exp_bundle(rst_vec)});

        for (int i = 0; i < 14; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Saturation: 17 more load-use stalls on a 4-bit counter.
        exp_cnt = 4'd2;
        for (int i = 0; i < 17; i++) begin
            lw_vec  = mk(0, C_LW,  2'd0, 1, 7, 0, 32'h0000_7000, 32'h0, 32'h4, 0, 1, exp_cnt);
            runVector($sformatf("sat%0d_lw", i), lw_vec);
            exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
            use_vec = mk(0, C_ALU, 2'd2, 7, 3, 4, 32'h0000_0007, 32'h3, 32'h0, 1, 0, exp_cnt);
            runVector($sformatf("sat%0d_use", i), use_vec);
            use_vec.exp_stall = 1'b0;
            use_vec.exp_valid = 1'b1;
            runVector($sformatf("sat%0d_go", i), use_vec);
        end
        checkOutput("sat_final_cnt", {124'd0, bus.stall_cnt_o}, 128'd15);

        // Asynchronous reset while a stall is pending.
        lw_vec = mk(0, C_LW, 2'd0, 2, 9, 0, 32'h0000_8000, 32'h0, 32'h8, 0, 1, 4'hF);
        runVector("ar_lw", lw_vec);
        use_vec = mk(0, C_ALU, 2'd2, 3, 9, 10, 32'h0000_0003, 32'h0000_0009, 32'h0, 0, 1, 4'd0);
        applyStimulus(use_vec);
        #1;
        checkOutput("ar_stall_before", {127'd0, bus.stall_o}, 128'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("ar_stall_after", {127'd0, bus.stall_o}, 128'd0);
        checkOutput("ar_valid", {127'd0, bus.valid_o}, 128'd0);
        checkOutput("ar_cnt", {124'd0, bus.stall_cnt_o}, 128'd0);
        checkOutput("ar_bundle", {9'd0, act_bundle()}, 128'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ar_release_valid", {127'd0, bus.valid_o}, 128'd1);
        checkOutput("ar_release_bundle", {9'd0, act_bundle()}, {9'd0, exp_bundle(use_vec)});
        checkOutput("ar_release_cnt", {124'd0, bus.stall_cnt_o}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
